// File: rtl/multi_pulse_tracer.sv
// multi_pulse_tracer: per-channel debouncer with configurable edge pulses,
// sticky event flags and overrun flags.
// Optional macro PULSE_TRACER_SYNC_EN inserts a 2-flop synchronizer on each
// noisy_in bit ahead of the debouncer.
module multi_pulse_tracer #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [1:0]      edge_mode,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] pulse_out,
    output logic [N_CH-1:0] event_flag,
    output logic [N_CH-1:0] overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [N_CH-1:0]            s;
    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic [N_CH-1:0][CNT_W-1:0] cnt_next;
    logic [N_CH-1:0]            deb_next;
    logic [N_CH-1:0]            pulse_next;
    logic [N_CH-1:0]            flag_next;
    logic [N_CH-1:0]            ovr_next;

`ifdef PULSE_TRACER_SYNC_EN
    logic [N_CH-1:0] sync_meta;
    logic [N_CH-1:0] sync_out;

    // Two-stage synchronizer for the raw inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= noisy_in;
            sync_out  <= sync_meta;
        end
    end

    // Debouncer samples the synchronized copy
    always_comb begin
        s = sync_out;
    end
`else
    // Debouncer samples the raw inputs directly
    always_comb begin
        s = noisy_in;
    end
`endif

    // Per-channel stability counting, level acceptance and edge qualification
    always_comb begin
        cnt_next   = cnt;
        deb_next   = debounced;
        pulse_next = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (s[i] == debounced[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                deb_next[i]   = s[i];
                cnt_next[i]   = '0;
                pulse_next[i] = s[i] ? edge_mode[0] : edge_mode[1];
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Sticky flags: a pulse beats a clear for event_flag; a clear beats a
    // pulse for overrun
    always_comb begin
        flag_next = pulse_out | (event_flag & ~evt_clr);
        ovr_next  = ~evt_clr & (overrun | (pulse_out & event_flag));
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            debounced  <= '0;
            pulse_out  <= '0;
            event_flag <= '0;
            overrun    <= '0;
        end else begin
            cnt        <= cnt_next;
            debounced  <= deb_next;
            pulse_out  <= pulse_next;
            event_flag <= flag_next;
            overrun    <= ovr_next;
        end
    end

endmodule

// File: tb/tb_multi_pulse_tracer.sv
// Self-checking bench for multi_pulse_tracer (N_CH=4, STABLE_CNT=4).
// Reference model works on sampling-edge timestamps: a level is accepted once
// STABLE_CNT samples have passed since the last sample matching the level.
module tb_multi_pulse_tracer;

    localparam int N_CH       = 4;
    localparam int STABLE_CNT = 4;
`ifdef PULSE_TRACER_SYNC_EN
    localparam int LAT = STABLE_CNT + 2;
`else
    localparam int LAT = STABLE_CNT;
`endif

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] noisy_in;
    logic [1:0]      edge_mode;
    logic [N_CH-1:0] evt_clr;
    logic [N_CH-1:0] debounced;
    logic [N_CH-1:0] pulse_out;
    logic [N_CH-1:0] event_flag;
    logic [N_CH-1:0] overrun;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [N_CH-1:0] m_deb, m_pulse, m_flag, m_ovr, p1, p2;
    int              t;
    int              last_match [N_CH];

    multi_pulse_tracer #(.N_CH(N_CH), .STABLE_CNT(STABLE_CNT), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .noisy_in   (noisy_in),
        .edge_mode  (edge_mode),
        .evt_clr    (evt_clr),
        .debounced  (debounced),
        .pulse_out  (pulse_out),
        .event_flag (event_flag),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_deb = '0; m_pulse = '0; m_flag = '0; m_ovr = '0; p1 = '0; p2 = '0;
        for (int c = 0; c < N_CH; c++) last_match[c] = t;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".debounced"}, debounced, m_deb);
        check({tag, ".pulse_out"}, pulse_out, m_pulse);
        check({tag, ".event_flag"}, event_flag, m_flag);
        check({tag, ".overrun"}, overrun, m_ovr);
    endtask

    // one sampling edge: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input logic [N_CH-1:0] in, input logic [1:0] mode,
                        input logic [N_CH-1:0] clr, input string tag);
        logic [N_CH-1:0] samp, nf, no, np;
        noisy_in  = in;
        edge_mode = mode;
        evt_clr   = clr;
        @(posedge clk);
        t++;
`ifdef PULSE_TRACER_SYNC_EN
        samp = p2;
        p2   = p1;
        p1   = in;
`else
        samp = in;
`endif
        nf = m_pulse | (m_flag & ~clr);
        no = ~clr & (m_ovr | (m_pulse & m_flag));
        np = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (samp[c] == m_deb[c]) begin
                last_match[c] = t;
            end else if (t - last_match[c] >= STABLE_CNT) begin
                m_deb[c]      = samp[c];
                last_match[c] = t;
                np[c]         = samp[c] ? mode[0] : mode[1];
            end
        end
        m_pulse = np;
        m_flag  = nf;
        m_ovr   = no;
        @(negedge clk);
        compare_model(tag);
    endtask

    // asynchronous reset pulse starting mid-cycle, held over one rising edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_debounced"}, debounced, '0);
        check({tag, ".rst_pulse_out"}, pulse_out, '0);
        check({tag, ".rst_event_flag"}, event_flag, '0);
        check({tag, ".rst_overrun"}, overrun, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N_CH-1:0] cur;
        logic [1:0]      mode;
        t         = 0;
        rst_n     = 1'b0;
        noisy_in  = '0;
        edge_mode = 2'b11;
        evt_clr   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.debounced", debounced, '0);
        check("reset.pulse_out", pulse_out, '0);
        check("reset.event_flag", event_flag, '0);
        check("reset.overrun", overrun, '0);
        rst_n = 1'b1;

        // channel 0 held high: accepted on the LAT-th edge
        for (int k = 1; k < LAT; k++) step(4'b0001, 2'b11, '0, "ch0_hold");
        check("ch0_early.debounced", debounced, 4'b0000);
        step(4'b0001, 2'b11, '0, "ch0_accept");
        check("ch0_accept.debounced", debounced, 4'b0001);
        check("ch0_accept.pulse", pulse_out, 4'b0001);
        step(4'b0001, 2'b11, '0, "ch0_after");
        check("ch0_after.pulse", pulse_out, 4'b0000);
        check("ch0_after.flag", event_flag, 4'b0001);

        // channel 1 glitch restarts the count
        begin
            logic [7:0] pat;
            pat = 8'b1110_1111;
            for (int k = 7; k >= 0; k--) step({2'b00, pat[k], 1'b1}, 2'b11, '0, "ch1_glitch");
            for (int k = 0; k < LAT - STABLE_CNT; k++) step(4'b0011, 2'b11, '0, "ch1_sync");
            check("ch1_glitch.debounced", debounced, 4'b0011);
        end

        // channel 2 with falling-only, then both edges
        evt_clr = 4'b0100;
        step(4'b0011, 2'b10, 4'b1111, "clear_all");
        repeat (6) step(4'b0111, 2'b10, '0, "ch2_rise_fall_mode");
        check("ch2_rise_mode10.flag", event_flag & 4'b0100, 4'b0000);
        repeat (6) step(4'b0011, 2'b10, '0, "ch2_fall_fall_mode");
        check("ch2_fall_mode10.flag", event_flag & 4'b0100, 4'b0100);
        repeat (6) step(4'b0111, 2'b11, '0, "ch2_rise_both");
        repeat (6) step(4'b0011, 2'b11, '0, "ch2_fall_both");
        check("ch2_both.overrun", overrun & 4'b0100, 4'b0100);

        // channel 3: two edges set overrun, clear coincident with third pulse
        step(4'b0011, 2'b11, 4'b1111, "clear_all2");
        repeat (6) step(4'b1011, 2'b11, '0, "ch3_rise");
        repeat (6) step(4'b0011, 2'b11, '0, "ch3_fall");
        check("ch3_two_edges.overrun", overrun & 4'b1000, 4'b1000);
        for (int k = 0; k < LAT; k++) step(4'b1011, 2'b11, '0, "ch3_rise2");
        check("ch3_third.pulse", pulse_out & 4'b1000, 4'b1000);
        step(4'b1011, 2'b11, 4'b1000, "ch3_clr_on_pulse");
        check("ch3_clr.flag", event_flag & 4'b1000, 4'b1000);
        check("ch3_clr.overrun", overrun & 4'b1000, 4'b0000);

        // reset mid-count discards partial progress
        repeat (8) step(4'b0000, 2'b11, '0, "all_low");
        repeat (2) step(4'b0001, 2'b11, '0, "partial");
        noisy_in = 4'b0001;
        do_reset("midcount");
        for (int k = 1; k < LAT; k++) step(4'b0001, 2'b11, '0, "post_reset");
        check("post_reset_early.debounced", debounced, 4'b0000);
        step(4'b0001, 2'b11, '0, "post_reset_accept");
        check("post_reset_accept.debounced", debounced, 4'b0001);

        // randomized traffic with sticky inputs, mode changes, clears and resets
        cur  = '0;
        mode = 2'b11;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                noisy_in = cur;
                do_reset("rand_reset");
            end
            step(cur, mode, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
